psg_write_sequencer: RTL and testbench
======================================

Name: psg_write_sequencer

Overview:
- Host-side write controller for the sn76489_top PSG core.
- Accepts abstract register-write commands (channel, tone/volume select, 10-bit value) through a valid/ready port and buffers them in a small FIFO.
- Expands each command into one or two PSG bus bytes (latch byte, plus a data byte where needed).
- Drives the PSG ce_n/we_n/d strobes and completes each byte only after the core's ready low-then-high handshake.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT, 255, maximum cycles spent in each ready-wait state before abort; range 1..65535.

Ports:
- clock_i  in  1  system clock; same clock as the PSG core.
- res_i  in  1  asynchronous active-high reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid & ready.
- cmd_chan_i  in  2  channel: 0-2 tone, 3 noise.
- cmd_vol_i  in  1  1 = attenuation write, 0 = tone/noise write.
- cmd_data_i  in  10  value; only the low bits used for the command type apply.
- psg_ce_n_o  out  1  PSG chip enable, active low.
- psg_we_n_o  out  1  PSG write enable, active low.
- psg_d_o  out  8  PSG data byte.
- psg_ready_i  in  1  PSG ready_o.
- busy_o  out  1  sequencer not idle or FIFO not empty.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_timeout_o  out  1  one-cycle pulse on handshake timeout.

Behaviour:
- Reset, asynchronous, while res_i = 1:
  - psg_ce_n_o = 1, psg_we_n_o = 1, psg_d_o = 0x00.
  - cmd_ready_o = 0, busy_o = 0, fifo_level_o = 0, err_timeout_o = 0.
  - FIFO emptied, FSM forced to IDLE.
  - Asserting reset mid-cycle releases the strobes immediately and discards the in-flight command.
- After reset, cmd_ready_o = !full. Push when valid & ready. A pop and a push in the same cycle are both allowed. cmd_ready_o is derived from full only, so a push is refused while full even if a pop occurs that cycle.
- Byte encoding, where c = cmd_chan_i and d = cmd_data_i:
  - Volume (vol = 1): one byte {1, c, 1, d[3:0]}.
  - Tone (vol = 0, c < 3): latch byte {1, c, 0, d[3:0]}, then data byte {0, 0, d[9:4]}.
  - Noise (vol = 0, c = 3): one byte {1, 1, 1, 0, 0, d[2:0]}.
- FSM states: IDLE, STROBE, WAIT_LO, WAIT_HI, GAP.
  - IDLE: if FIFO not empty, pop the head, build the byte list, load psg_d_o, go to STROBE.
  - STROBE: ce_n = we_n = 0 are registered. The first strobe cycle is 2 cycles after acceptance when the FIFO was empty and the FSM idle. Go to WAIT_LO, timer cleared.
  - WAIT_LO: strobes held low. psg_ready_i = 0 -> WAIT_HI, timer cleared. Timer reaching TIMEOUT -> abort.
  - WAIT_HI: strobes held low. psg_ready_i = 1 -> release both strobes the next cycle and go to GAP. Timer reaching TIMEOUT -> abort.
  - GAP: strobes high for exactly 1 cycle. If a second byte is pending, load it and go to STROBE. Otherwise go to IDLE.
- Abort:
  - Strobes released next cycle and err_timeout_o pulses for 1 cycle.
  - Any remaining byte of the command is dropped.
  - FSM goes to GAP, then IDLE; FIFO contents are kept.
- psg_d_o is stable from STROBE entry until the strobes release.
- ce_n and we_n always change together, never glitch, and are never low outside STROBE/WAIT_LO/WAIT_HI.
- busy_o = (state != IDLE) | (fifo_level_o != 0), registered.
- Unused cmd_data_i bits are ignored; there is no error for out-of-range values.

Test Plan:
- Volume write: chan 1, vol 1, data 0x3A5 → one byte 0xB5; strobes low until ready goes low then high; 1 gap cycle; back to idle, busy_o = 0.
- Tone write: chan 2, vol 0, data 0x2F3 → bytes 0xC3 then 0x2F, in order; each byte gets its own low/high ready handshake; exactly 1 strobe-high cycle between the bytes.
- Noise write plus FIFO full: chan 3, data 0x3FE → byte 0xE6. Then hold psg_ready_i = 1 (core stalled) and push FIFO_DEPTH+1 tone commands → cmd_ready_o = 0 after 4 accepted while one is in flight; fifo_level_o = 4.
- Timeout: TIMEOUT = 8, psg_ready_i held at 1 → err_timeout_o pulses once 9 cycles after STROBE; strobes released; the tone command's data byte is never issued; the next FIFO command proceeds.
- Reset mid-handshake: assert res_i during WAIT_HI of a tone latch byte → strobes high in the same cycle; FIFO empty; after release, no data byte is emitted and cmd_ready_o = 1.

Source files
------------

// File: rtl/psg_write_sequencer.sv
// Host-side write sequencer for the SN76489-style PSG core. Commands are queued in a
// small FIFO and expanded into latch/data bus bytes, each strobed with a ready handshake.
module psg_write_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clock_i,
    input  logic                          res_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [1:0]                    cmd_chan_i,
    input  logic                          cmd_vol_i,
    input  logic [9:0]                    cmd_data_i,
    output logic                          psg_ce_n_o,
    output logic                          psg_we_n_o,
    output logic [7:0]                    psg_d_o,
    input  logic                          psg_ready_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          err_timeout_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [15:0]   TMO_M1   = 16'(TIMEOUT - 1);

    typedef struct packed {
        logic [1:0] chan;
        logic       vol;
        logic [9:0] data;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_GAP
    } state_t;

    cmd_t            mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic            ready_q, busy_q;
    logic            push, pop, idle_next;

    state_t          state_q;
    logic            strobe_n_q;
    logic [7:0]      d_q, byte2_q;
    logic            pend_q, err_q;
    logic [15:0]     timer_q;

    cmd_t            head;
    logic [7:0]      b0, b1;
    logic            has2;

    assign push = cmd_valid_i & ready_q;
    assign pop  = (state_q == ST_IDLE) && (level_q != '0);

    // FSM lands in IDLE next cycle only from an empty IDLE or a GAP with no byte pending
    assign idle_next = ((state_q == ST_IDLE) && (level_q == '0)) ||
                       ((state_q == ST_GAP) && !pend_q);

    always_comb begin
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (!push && pop)
            level_d = level_q - LW'(1);
    end

    always_ff @(posedge clock_i) begin
        if (push)
            mem_q[wptr_q] <= '{chan: cmd_chan_i, vol: cmd_vol_i, data: cmd_data_i};
    end

    always_ff @(posedge clock_i or posedge res_i) begin
        if (res_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (push)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            level_q <= level_d;
            ready_q <= (level_d != FULL_LVL);
            busy_q  <= !idle_next || (level_d != '0);
        end
    end

    always_comb begin
        head = mem_q[rptr_q];
        b1   = {2'b00, head.data[9:4]};
        has2 = 1'b0;
        if (head.vol) begin
            b0 = {1'b1, head.chan, 1'b1, head.data[3:0]};
        end else if (head.chan == 2'd3) begin
            b0 = {5'b11100, head.data[2:0]};
        end else begin
            b0   = {1'b1, head.chan, 1'b0, head.data[3:0]};
            has2 = 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge res_i) begin
        if (res_i) begin
            state_q    <= ST_IDLE;
            strobe_n_q <= 1'b1;
            d_q        <= 8'h00;
            byte2_q    <= 8'h00;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            timer_q    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (level_q != '0) begin
                        d_q        <= b0;
                        byte2_q    <= b1;
                        pend_q     <= has2;
                        strobe_n_q <= 1'b0;
                        state_q    <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT_LO;
                end
                ST_WAIT_LO, ST_WAIT_HI: begin
                    if ((state_q == ST_WAIT_LO) && !psg_ready_i) begin
                        timer_q <= '0;
                        state_q <= ST_WAIT_HI;
                    end else if ((state_q == ST_WAIT_HI) && psg_ready_i) begin
                        strobe_n_q <= 1'b1;
                        state_q    <= ST_GAP;
                    end else if (timer_q == TMO_M1) begin
                        // abort: drop any pending data byte, keep the queue intact
                        strobe_n_q <= 1'b1;
                        err_q      <= 1'b1;
                        pend_q     <= 1'b0;
                        state_q    <= ST_GAP;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (pend_q) begin
                        d_q        <= byte2_q;
                        pend_q     <= 1'b0;
                        strobe_n_q <= 1'b0;
                        state_q    <= ST_STROBE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = ready_q;
    assign psg_ce_n_o    = strobe_n_q;
    assign psg_we_n_o    = strobe_n_q;
    assign psg_d_o       = d_q;
    assign busy_o        = busy_q;
    assign fifo_level_o  = level_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_psg_write_sequencer.sv
// Directed bench for psg_write_sequencer: table of single commands with their expected
// bus bytes, plus hand sequences for FIFO full, handshake timeout and mid-write reset.
module tb_psg_write_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_vol;
    logic [1:0] cmd_chan;
    logic [9:0] cmd_data;
    logic       ce_n, we_n, psg_ready, busy, err;
    logic [7:0] d;
    logic [2:0] level;

    int n_pass = 0;
    int n_total = 0;

    psg_write_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clock_i       (clk),
        .res_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_chan_i    (cmd_chan),
        .cmd_vol_i     (cmd_vol),
        .cmd_data_i    (cmd_data),
        .psg_ce_n_o    (ce_n),
        .psg_we_n_o    (we_n),
        .psg_d_o       (d),
        .psg_ready_i   (psg_ready),
        .busy_o        (busy),
        .fifo_level_o  (level),
        .err_timeout_o (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] chan;
        logic       vol;
        logic [9:0] data;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;

    vec_t vecs [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic send(input logic [1:0] c, input logic v, input logic [9:0] dat);
        cmd_valid = 1'b1;
        cmd_chan  = c;
        cmd_vol   = v;
        cmd_data  = dat;
        tick();
        cmd_valid = 1'b0;
    endtask

    // entered in the STROBE cycle; leaves in the GAP cycle
    task automatic handshake(input string tag, input logic [7:0] b);
        chk({tag, "_d"}, d, b);
        chk({tag, "_ce_lo"}, ce_n, 0);
        chk({tag, "_we_lo"}, we_n, 0);
        tick();
        chk({tag, "_waitlo_ce"}, ce_n, 0);
        psg_ready = 1'b0;
        tick();
        chk({tag, "_waithi_ce"}, ce_n, 0);
        tick();
        chk({tag, "_waithi_we"}, we_n, 0);
        chk({tag, "_d_stable"}, d, b);
        psg_ready = 1'b1;
        tick();
        chk({tag, "_gap_ce"}, ce_n, 1);
        chk({tag, "_gap_we"}, we_n, 1);
        chk({tag, "_gap_busy"}, busy, 1);
    endtask

    task automatic run_vec(input int i);
        send(vecs[i].chan, vecs[i].vol, vecs[i].data);
        chk($sformatf("v%0d_lat_ce", i), ce_n, 1);
        tick();
        handshake($sformatf("v%0d_b0", i), vecs[i].b0);
        tick();
        if (vecs[i].nbytes == 2) begin
            handshake($sformatf("v%0d_b1", i), vecs[i].b1);
            tick();
        end
        chk($sformatf("v%0d_idle_ce", i), ce_n, 1);
        chk($sformatf("v%0d_idle_busy", i), busy, 0);
        chk($sformatf("v%0d_idle_rdy", i), cmd_ready, 1);
    endtask

    initial begin
        int lows;
        vecs[0] = '{2'd1, 1'b1, 10'h3A5, 1, 8'hB5, 8'h00};
        vecs[1] = '{2'd2, 1'b0, 10'h2F3, 2, 8'hC3, 8'h2F};
        vecs[2] = '{2'd3, 1'b0, 10'h3FE, 1, 8'hE6, 8'h00};
        vecs[3] = '{2'd0, 1'b0, 10'h3FF, 2, 8'h8F, 8'h3F};
        vecs[4] = '{2'd3, 1'b1, 10'h00F, 1, 8'hFF, 8'h00};
        vecs[5] = '{2'd3, 1'b0, 10'h001, 1, 8'hE1, 8'h00};
        vecs[6] = '{2'd1, 1'b0, 10'h000, 2, 8'hA0, 8'h00};
        vecs[7] = '{2'd0, 1'b1, 10'h3F0, 1, 8'h90, 8'h00};

        rst = 1'b1; cmd_valid = 1'b0; cmd_chan = '0; cmd_vol = 1'b0; cmd_data = '0;
        psg_ready = 1'b1;
        #2;
        chk("rst_ce", ce_n, 1);
        chk("rst_we", we_n, 1);
        chk("rst_d", d, 8'h00);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_err", err, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", cmd_ready, 1);

        for (int i = 0; i < 8; i++) run_vec(i);

        // FIFO full while the noise byte is stalled on a ready-high core
        send(2'd3, 1'b0, 10'h3FE);
        cmd_valid = 1'b1; cmd_chan = 2'd0; cmd_vol = 1'b0; cmd_data = 10'h123;
        tick();
        chk("full_noise_d", d, 8'hE6);
        chk("full_noise_ce", ce_n, 0);
        tick(); tick(); tick();
        chk("full_ready", cmd_ready, 0);
        chk("full_level", level, 4);
        tick();
        chk("full_level_hold", level, 4);
        chk("full_busy", busy, 1);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("full_rst_ce", ce_n, 1);
        chk("full_rst_level", level, 0);
        tick();
        rst = 1'b0;
        tick();

        // timeout on a tone latch byte; its data byte must never appear
        send(2'd0, 1'b0, 10'h155);
        send(2'd2, 1'b1, 10'h007);
        chk("tmo_latch_d", d, 8'h85);
        chk("tmo_latch_ce", ce_n, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("tmo_wait%0d_err", k), err, 0);
            chk($sformatf("tmo_wait%0d_ce", k), ce_n, 0);
        end
        tick();
        chk("tmo_err_pulse", err, 1);
        chk("tmo_rel_ce", ce_n, 1);
        chk("tmo_rel_we", we_n, 1);
        tick();
        chk("tmo_err_once", err, 0);
        chk("tmo_idle_ce", ce_n, 1);
        tick();
        handshake("tmo_next", 8'hD7);
        tick();
        chk("tmo_end_busy", busy, 0);
        chk("tmo_end_err", err, 0);

        // reset during WAIT_HI of a tone latch byte
        send(2'd2, 1'b0, 10'h2F3);
        tick();
        chk("rmid_d", d, 8'hC3);
        tick();
        psg_ready = 1'b0;
        tick();
        chk("rmid_waithi_ce", ce_n, 0);
        rst = 1'b1;
        #1;
        chk("rmid_ce", ce_n, 1);
        chk("rmid_we", we_n, 1);
        chk("rmid_level", level, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_ready", cmd_ready, 0);
        tick();
        rst = 1'b0;
        psg_ready = 1'b1;
        tick();
        chk("rmid_post_ready", cmd_ready, 1);
        lows = 0;
        for (int k = 0; k < 12; k++) begin
            if (ce_n == 1'b0 || we_n == 1'b0) lows++;
            tick();
        end
        chk("rmid_no_data_byte", lows, 0);
        chk("rmid_post_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
